// File: rtl/cache_fill_arbiter_if.sv
// Bundle of cache request, store, memory and fill signals around the fill arbiter.
// The master view belongs to the arbiter and the slave view to the caches and memory.
interface cache_fill_arbiter_if #(
    parameter int AW        = 16,
    parameter int DW        = 16,
    parameter int BLK_WORDS = 8
);
    localparam int WORD_BITS = $clog2(BLK_WORDS);

    logic                 i_miss;
    logic [AW-1:0]        i_miss_addr;
    logic                 d_miss;
    logic [AW-1:0]        d_miss_addr;
    logic                 d_wr;
    logic [AW-1:0]        d_wr_addr;
    logic [DW-1:0]        d_wr_data;
    logic                 d_wr_ack;

    logic                 mem_en;
    logic                 mem_wr;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_wdata;
    logic                 mem_data_valid;
    logic [DW-1:0]        mem_rdata;

    logic                 fill_we_i;
    logic                 fill_we_d;
    logic [WORD_BITS-1:0] fill_word;
    logic [DW-1:0]        fill_data;
    logic                 fill_tag_we_i;
    logic                 fill_tag_we_d;
    logic                 fill_done_i;
    logic                 fill_done_d;
    logic                 busy;

    modport master (
        input  i_miss, i_miss_addr, d_miss, d_miss_addr,
        input  d_wr, d_wr_addr, d_wr_data,
        output d_wr_ack,
        output mem_en, mem_wr, mem_addr, mem_wdata,
        input  mem_data_valid, mem_rdata,
        output fill_we_i, fill_we_d, fill_word, fill_data,
        output fill_tag_we_i, fill_tag_we_d, fill_done_i, fill_done_d,
        output busy
    );

    modport slave (
        output i_miss, i_miss_addr, d_miss, d_miss_addr,
        output d_wr, d_wr_addr, d_wr_data,
        input  d_wr_ack,
        input  mem_en, mem_wr, mem_addr, mem_wdata,
        output mem_data_valid, mem_rdata,
        input  fill_we_i, fill_we_d, fill_word, fill_data,
        input  fill_tag_we_i, fill_tag_we_d, fill_done_i, fill_done_d,
        input  busy
    );
endinterface

// File: rtl/cache_fill_arbiter.sv
// Sole owner of main memory: arbitrates I/D block fills and D-cache write-through
// stores, issues pipelined block reads and steers returning words into the caches.
module cache_fill_arbiter #(
    parameter int MEM_LAT   = 4,
    parameter int BLK_WORDS = 8,
    parameter int AW        = 16,
    parameter int DW        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    cache_fill_arbiter_if.master  bus
);
    localparam int WORD_BITS = $clog2(BLK_WORDS);
    localparam int OFF_BITS  = WORD_BITS + 1;

    localparam logic [WORD_BITS:0]   BLK_CNT   = (WORD_BITS+1)'(BLK_WORDS);
    localparam logic [WORD_BITS:0]   ISSUE_ONE = (WORD_BITS+1)'(1);
    localparam logic [WORD_BITS-1:0] RECV_ONE  = WORD_BITS'(1);
    localparam logic [WORD_BITS-1:0] LAST_WORD = WORD_BITS'(BLK_WORDS - 1);
    localparam logic [AW-1:0]        OFF_MASK  = AW'((1 << OFF_BITS) - 1);

    // Block must be a power of two words and fit in the address; memory must have latency.
    if (MEM_LAT < 1 || DW < 1 || AW <= OFF_BITS || BLK_WORDS != (1 << WORD_BITS)) begin : g_param_check
        $error("cache_fill_arbiter: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL_I,
        S_FILL_D,
        S_DONE_I,
        S_DONE_D
    } state_t;

    state_t               state_q, state_d;
    logic [WORD_BITS:0]   issue_cnt_q, issue_cnt_d;
    logic [WORD_BITS-1:0] recv_cnt_q, recv_cnt_d;
    logic [AW-1:0]        base_q, base_d;
    logic                 last_i_q, last_i_d;
    logic                 grant_i;
    logic                 grant_d;

    // Round-robin tie break: I wins a tie only when D had the previous fill.
    assign grant_i = bus.i_miss && (!bus.d_miss || !last_i_q);
    assign grant_d = bus.d_miss && !grant_i;

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        base_d      = base_q;
        last_i_d    = last_i_q;

        bus.d_wr_ack      = 1'b0;
        bus.mem_en        = 1'b0;
        bus.mem_wr        = 1'b0;
        bus.mem_addr      = '0;
        bus.mem_wdata     = '0;
        bus.fill_we_i     = 1'b0;
        bus.fill_we_d     = 1'b0;
        bus.fill_word     = '0;
        bus.fill_data     = '0;
        bus.fill_tag_we_i = 1'b0;
        bus.fill_tag_we_d = 1'b0;
        bus.fill_done_i   = 1'b0;
        bus.fill_done_d   = 1'b0;
        bus.busy          = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (bus.d_wr) begin
                    bus.mem_en    = 1'b1;
                    bus.mem_wr    = 1'b1;
                    bus.mem_addr  = bus.d_wr_addr;
                    bus.mem_wdata = bus.d_wr_data;
                    bus.d_wr_ack  = 1'b1;
                end else if (grant_i) begin
                    base_d   = bus.i_miss_addr & ~OFF_MASK;
                    last_i_d = 1'b1;
                    state_d  = S_FILL_I;
                end else if (grant_d) begin
                    base_d   = bus.d_miss_addr & ~OFF_MASK;
                    last_i_d = 1'b0;
                    state_d  = S_FILL_D;
                end
            end

            S_FILL_I, S_FILL_D: begin
                if (issue_cnt_q < BLK_CNT) begin
                    bus.mem_en   = 1'b1;
                    bus.mem_addr = base_q | AW'({issue_cnt_q[WORD_BITS-1:0], 1'b0});
                    issue_cnt_d  = issue_cnt_q + ISSUE_ONE;
                end
                // Reads return in issue order, so the receive count is the word index.
                if (bus.mem_data_valid) begin
                    bus.fill_we_i = (state_q == S_FILL_I);
                    bus.fill_we_d = (state_q == S_FILL_D);
                    bus.fill_word = recv_cnt_q;
                    bus.fill_data = bus.mem_rdata;
                    recv_cnt_d    = recv_cnt_q + RECV_ONE;
                    if (recv_cnt_q == LAST_WORD) begin
                        bus.fill_tag_we_i = (state_q == S_FILL_I);
                        bus.fill_tag_we_d = (state_q == S_FILL_D);
                        state_d = (state_q == S_FILL_I) ? S_DONE_I : S_DONE_D;
                    end
                end
            end

            S_DONE_I, S_DONE_D: begin
                bus.fill_done_i = (state_q == S_DONE_I);
                bus.fill_done_d = (state_q == S_DONE_D);
                issue_cnt_d     = '0;
                recv_cnt_d      = '0;
                state_d         = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            base_q      <= '0;
            last_i_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            base_q      <= base_d;
            last_i_q    <= last_i_d;
        end
    end
endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter: IDLE store/arbitration vector table plus
// hand-written fill sequences against a 4-cycle pipelined memory model.
module tb_cache_fill_arbiter;
    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    cache_fill_arbiter_if #(.AW(16), .DW(16), .BLK_WORDS(8)) bus ();

    cache_fill_arbiter #(
        .MEM_LAT   (4),
        .BLK_WORDS (8),
        .AW        (16),
        .DW        (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: read issued in cycle t returns data (addr ^ 0x5A5A) in cycle t+4.
    logic [3:0]  pv = '0;
    logic [15:0] pa [4];
    initial for (int i = 0; i < 4; i++) pa[i] = '0;
    always @(posedge clk) begin
        pv    <= {pv[2:0], bus.mem_en && !bus.mem_wr};
        pa[0] <= bus.mem_addr;
        pa[1] <= pa[0];
        pa[2] <= pa[1];
        pa[3] <= pa[2];
    end
    assign bus.mem_data_valid = pv[3];
    assign bus.mem_rdata      = pa[3] ^ 16'h5A5A;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_quiet(input string name);
        chk16({name, "_flags"}, 16'({bus.busy, bus.mem_en, bus.mem_wr, bus.d_wr_ack,
                                    bus.fill_we_i, bus.fill_we_d, bus.fill_tag_we_i,
                                    bus.fill_tag_we_d, bus.fill_done_i, bus.fill_done_d}), 16'h0000);
        chk16({name, "_mem_addr"},  bus.mem_addr,  16'h0000);
        chk16({name, "_mem_wdata"}, bus.mem_wdata, 16'h0000);
        chk16({name, "_fill_data"}, bus.fill_data, 16'h0000);
        chk16({name, "_fill_word"}, 16'(bus.fill_word), 16'h0000);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_quiet("reset");
        $display("reset applied");
    endtask

    // Called in the grant cycle G with the miss already driven; ends at the DONE cycle.
    task automatic check_fill(input bit is_i, input logic [15:0] base, input int drop_at, input int wr_at);
        logic [15:0] exp_addr;
        @(negedge clk);
        chk1("grant_busy", bus.busy, 1'b0);
        chk1("grant_mem_en", bus.mem_en, 1'b0);
        for (int k = 1; k <= 13; k++) begin
            tick();
            if (k == drop_at) begin
                if (is_i) begin
                    bus.i_miss = 1'b0;
                    bus.i_miss_addr = 16'hFFFE;
                end else begin
                    bus.d_miss = 1'b0;
                    bus.d_miss_addr = 16'hFFFE;
                end
            end
            if (k == wr_at) begin
                bus.d_wr      = 1'b1;
                bus.d_wr_addr = 16'h0040;
                bus.d_wr_data = 16'hBEEF;
            end
            @(negedge clk);
            chk1("fill_busy", bus.busy, 1'b1);
            chk1("fill_mem_en", bus.mem_en, k <= 8);
            chk1("fill_mem_wr", bus.mem_wr, 1'b0);
            chk1("fill_wr_ack", bus.d_wr_ack, 1'b0);
            if (k <= 8) begin
                exp_addr = base + 16'(2 * (k - 1));
                chk16("fill_mem_addr", bus.mem_addr, exp_addr);
            end
            chk1("fill_we_own", is_i ? bus.fill_we_i : bus.fill_we_d, k >= 5 && k <= 12);
            chk1("fill_we_other", is_i ? bus.fill_we_d : bus.fill_we_i, 1'b0);
            if (k >= 5 && k <= 12) begin
                exp_addr = base + 16'(2 * (k - 5));
                chk16("fill_word", 16'(bus.fill_word), 16'(k - 5));
                chk16("fill_data", bus.fill_data, exp_addr ^ 16'h5A5A);
            end
            chk1("tag_we_own", is_i ? bus.fill_tag_we_i : bus.fill_tag_we_d, k == 12);
            chk1("tag_we_other", is_i ? bus.fill_tag_we_d : bus.fill_tag_we_i, 1'b0);
            chk1("done_own", is_i ? bus.fill_done_i : bus.fill_done_d, k == 13);
            chk1("done_other", is_i ? bus.fill_done_d : bus.fill_done_i, 1'b0);
        end
        $display("fill %s base=0x%04h completed sequence", is_i ? "I" : "D", base);
    endtask

    typedef struct {
        logic        d_wr;
        logic [15:0] wa;
        logic [15:0] wd;
        logic        i_miss;
        logic        d_miss;
        logic        e_en;
        logic        e_wr;
        logic [15:0] e_addr;
        logic [15:0] e_wdata;
        logic        e_ack;
        logic        e_busy;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 16'h0040, 16'hBEEF, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0040, 16'hBEEF, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 16'hFFFE, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFE, 16'h0001, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 16'hFFFF, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 16'h1234, 16'h5678, 1'b1, 1'b1, 1'b1, 1'b1, 16'h1234, 16'h5678, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};

        rst             = 1'b1;
        bus.i_miss      = 1'b0;
        bus.i_miss_addr = 16'h1236;
        bus.d_miss      = 1'b0;
        bus.d_miss_addr = 16'h0000;
        bus.d_wr        = 1'b0;
        bus.d_wr_addr   = 16'h0000;
        bus.d_wr_data   = 16'h0000;

        apply_reset();

        // IDLE stores and store-over-miss priority; busy stays low, so no grant happened.
        for (int r = 0; r < 6; r++) begin
            tick();
            bus.d_wr      = vecs[r].d_wr;
            bus.d_wr_addr = vecs[r].wa;
            bus.d_wr_data = vecs[r].wd;
            bus.i_miss    = vecs[r].i_miss;
            bus.d_miss    = vecs[r].d_miss;
            @(negedge clk);
            chk1("vec_mem_en", bus.mem_en, vecs[r].e_en);
            chk1("vec_mem_wr", bus.mem_wr, vecs[r].e_wr);
            chk16("vec_mem_addr", bus.mem_addr, vecs[r].e_addr);
            chk16("vec_mem_wdata", bus.mem_wdata, vecs[r].e_wdata);
            chk1("vec_wr_ack", bus.d_wr_ack, vecs[r].e_ack);
            chk1("vec_busy", bus.busy, vecs[r].e_busy);
            $display("vec %0d d_wr=%0b i=%0b d=%0b mem_en=%0b addr=0x%04h", r,
                     vecs[r].d_wr, vecs[r].i_miss, vecs[r].d_miss, bus.mem_en, bus.mem_addr);
        end

        // Single I fill from 0x1236.
        tick();
        bus.i_miss      = 1'b1;
        bus.i_miss_addr = 16'h1236;
        check_fill(1'b1, 16'h1230, 0, 0);
        tick();
        bus.i_miss = 1'b0;
        @(negedge clk);
        chk1("post_fill_busy", bus.busy, 1'b0);
        chk1("post_fill_mem_en", bus.mem_en, 1'b0);

        // Store raised during a D fill waits for the first IDLE cycle.
        tick();
        bus.d_miss      = 1'b1;
        bus.d_miss_addr = 16'h2008;
        check_fill(1'b0, 16'h2000, 0, 3);
        tick();
        bus.d_miss = 1'b0;
        @(negedge clk);
        chk1("held_store_en", bus.mem_en, 1'b1);
        chk1("held_store_wr", bus.mem_wr, 1'b1);
        chk16("held_store_addr", bus.mem_addr, 16'h0040);
        chk16("held_store_wdata", bus.mem_wdata, 16'hBEEF);
        chk1("held_store_ack", bus.d_wr_ack, 1'b1);
        chk1("held_store_busy", bus.busy, 1'b0);
        $display("held store addr=0x%04h data=0x%04h", bus.mem_addr, bus.mem_wdata);
        tick();
        bus.d_wr = 1'b0;
        @(negedge clk);
        chk1("after_store_ack", bus.d_wr_ack, 1'b0);

        // Store and D miss together: store first, fill granted the next cycle.
        tick();
        bus.d_wr        = 1'b1;
        bus.d_wr_addr   = 16'h0102;
        bus.d_wr_data   = 16'h1357;
        bus.d_miss      = 1'b1;
        bus.d_miss_addr = 16'h0520;
        @(negedge clk);
        chk1("wr_miss_ack", bus.d_wr_ack, 1'b1);
        chk1("wr_miss_wr", bus.mem_wr, 1'b1);
        chk16("wr_miss_addr", bus.mem_addr, 16'h0102);
        chk1("wr_miss_busy", bus.busy, 1'b0);
        $display("store before fill addr=0x%04h", bus.mem_addr);
        tick();
        bus.d_wr = 1'b0;
        check_fill(1'b0, 16'h0520, 0, 0);
        tick();
        bus.d_miss = 1'b0;

        // Both misses held after reset: I, D, I, D.
        apply_reset();
        tick();
        bus.i_miss      = 1'b1;
        bus.i_miss_addr = 16'h0100;
        bus.d_miss      = 1'b1;
        bus.d_miss_addr = 16'h0208;
        check_fill(1'b1, 16'h0100, 0, 0);
        tick();
        check_fill(1'b0, 16'h0200, 0, 0);
        tick();
        check_fill(1'b1, 16'h0100, 0, 0);
        tick();
        check_fill(1'b0, 16'h0200, 0, 0);
        tick();
        bus.i_miss = 1'b0;
        bus.d_miss = 1'b0;
        @(negedge clk);
        chk1("alt_end_busy", bus.busy, 1'b0);

        // Reset while word 3 of an I fill is arriving; later returns must be ignored.
        tick();
        bus.i_miss      = 1'b1;
        bus.i_miss_addr = 16'h3004;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 8) begin
                rst        = 1'b1;
                bus.i_miss = 1'b0;
            end
        end
        @(negedge clk);
        chk1("rst_mid_we", bus.fill_we_i, 1'b1);
        chk16("rst_mid_word", 16'(bus.fill_word), 16'h0003);
        for (int k = 9; k <= 12; k++) begin
            tick();
            rst = 1'b0;
            @(negedge clk);
            check_quiet("rst_mid_after");
        end
        $display("reset mid-fill: stale returns ignored");
        tick();
        bus.i_miss      = 1'b1;
        bus.i_miss_addr = 16'h3012;
        check_fill(1'b1, 16'h3010, 0, 0);
        tick();
        bus.i_miss = 1'b0;

        // Miss dropped and address changed mid-fill: fill completes from the latched base.
        tick();
        bus.i_miss      = 1'b1;
        bus.i_miss_addr = 16'h4A5C;
        check_fill(1'b1, 16'h4A50, 3, 0);
        tick();
        @(negedge clk);
        chk1("drop_end_busy", bus.busy, 1'b0);
        chk1("drop_end_mem_en", bus.mem_en, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
